mult_stimulus_checker: RTL and testbench
========================================

Name: mult_stimulus_checker

Overview:
Self-checking stimulus and response stage placed directly around the combinational `multiplier` (ports A, B, P). It generates pseudo-random operand pairs from an LFSR, drives A/B into the multiplier, and waits a programmable settle time. It then samples P, compares it against an internal golden product, and accumulates pass/fail statistics. It replaces the per-case print-and-compare flow with an on-chip run that is suitable for both simulation and FPGA.

Parameters:
WIDTH, 2, operand width of A and B; legal range 1..8; P is 2*WIDTH bits.
NUM_TESTS, 20, number of operand pairs applied per run; legal range 1..65535.
SETTLE_CYCLES, 1, cycles A/B are held before P is sampled; legal range 1..15.
LFSR_SEED, 16'hACE1, LFSR value loaded on reset and on every accepted start; must be nonzero.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
A  output  WIDTH  operand A to the multiplier (registered).
B  output  WIDTH  operand B to the multiplier (registered).
P  input  2*WIDTH  product returned by the multiplier.
busy  output  1  high in LOAD, SETTLE and CHECK.
done  output  1  high while in DONE.
pass  output  1  valid when done=1; set when err_count==0.
test_count  output  16  number of completed checks in the current run.
err_count  output  16  number of mismatches, saturating at 16'hFFFF.
fail_a  output  WIDTH  A value of the most recent mismatch.
fail_b  output  WIDTH  B value of the most recent mismatch.
fail_p  output  2*WIDTH  P value of the most recent mismatch.

Behaviour:
- Reset (rst=1 at a rising edge), from any state:
  - state=IDLE, lfsr=LFSR_SEED.
  - A=0, B=0, busy=0, done=0, pass=0.
  - test_count=0, err_count=0, fail_a=0, fail_b=0, fail_p=0.
  - Reset during a run aborts it; no partial results are retained.
- LFSR: 16-bit Galois, shift right.
  - next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 16'h0000).
  - Operand mapping: A=next[WIDTH-1:0], B=next[2*WIDTH-1:WIDTH].
- FSM states: IDLE, LOAD, SETTLE, CHECK, DONE.
  - IDLE: start=1 -> lfsr<=LFSR_SEED, test_count<=0, err_count<=0, clear fail_*, go to LOAD.
  - LOAD (1 cycle): lfsr<=next; A<=mapped A; B<=mapped B; settle counter<=0; go to SETTLE.
  - SETTLE: counter increments each cycle; after SETTLE_CYCLES cycles, go to CHECK.
  - CHECK (1 cycle): compare P against golden = A*B, computed at 2*WIDTH unsigned with no truncation; test_count+=1.
    - On mismatch: err_count+=1 (saturating); fail_a/fail_b/fail_p <= A/B/P.
    - If the updated test_count==NUM_TESTS, go to DONE; otherwise go to LOAD.
  - DONE: done=1; pass=(err_count==0); A/B hold their last values; all counters hold.
    - start=1 restarts exactly as from IDLE (same seed, so the operand sequence repeats).
- Timing:
  - Each test costs 2+SETTLE_CYCLES cycles.
  - done rises on edge 1+NUM_TESTS*(2+SETTLE_CYCLES) counted from the edge that sampled start.
- start is ignored while busy=1.
- rst has priority over start when both are asserted at the same edge.
- P is used only in CHECK; its value in other states is don't-care.
- pass is 0 at all times when done=0.

Test Plan:
1. Ideal multiplier model (P=A*B), defaults, start pulsed once -> done on edge 61 after start; test_count=20; err_count=0; pass=1.
2. First operands with defaults -> after the 1st LOAD, A=0,B=0 (lfsr=16'hE270); 2nd LOAD A=0,B=2 (16'h7138); 3rd LOAD A=0,B=3 (16'h389C).
3. Faulty model P=A*B+1 -> done with err_count=20, pass=0; fail_a/fail_b equal the 20th operands and fail_p equals their product+1.
4. Start pulsed repeatedly during busy -> run completes unchanged at edge 61; test_count=20 and no restart. A start in DONE reproduces the identical A/B sequence from scenario 2.
5. rst asserted during SETTLE of test 7 -> next cycle IDLE; A=B=0; test_count=0; err_count=0; busy=0; done=0. A subsequent start runs all 20 tests.
6. SETTLE_CYCLES=3, NUM_TESTS=1 -> A/B held for 3 cycles before CHECK; done on edge 6 after start; test_count=1.

Source files
------------

// File: rtl/mult_if.sv
// rtl/mult_if.sv - operand/product bundle between the stimulus checker and the multiplier
interface mult_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2*WIDTH-1:0] P;

    modport master (output A, output B, input P);
    modport slave  (input A, input B, output P);
endinterface

// File: rtl/mult_stimulus_checker.sv
// rtl/mult_stimulus_checker.sv - LFSR-driven stimulus and golden-product checker around a combinational multiplier
module mult_stimulus_checker #(
    parameter int          WIDTH         = 2,
    parameter int          NUM_TESTS     = 20,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    mult_if.master               mif,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          test_count,
    output logic [15:0]          err_count,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic [2*WIDTH-1:0]   fail_p
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TEST_LAST   = 16'(NUM_TESTS);

    logic [2:0]         r_state;
    logic [15:0]        r_lfsr;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_settle;
    logic [15:0]        r_test_count;
    logic [15:0]        r_err_count;
    logic [WIDTH-1:0]   r_fail_a;
    logic [WIDTH-1:0]   r_fail_b;
    logic [2*WIDTH-1:0] r_fail_p;

    logic [15:0]        w_lfsr_next;
    logic [2*WIDTH-1:0] w_golden;
    logic [15:0]        w_tc_next;

    // Galois form, shifting right, taps 16,14,13,11
    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_golden    = (2*WIDTH)'(r_a) * (2*WIDTH)'(r_b);
    assign w_tc_next   = r_test_count + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lfsr       <= LFSR_SEED;
            r_a          <= '0;
            r_b          <= '0;
            r_settle     <= '0;
            r_test_count <= '0;
            r_err_count  <= '0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_p     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_lfsr       <= LFSR_SEED;
                        r_test_count <= '0;
                        r_err_count  <= '0;
                        r_fail_a     <= '0;
                        r_fail_b     <= '0;
                        r_fail_p     <= '0;
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_lfsr   <= w_lfsr_next;
                    r_a      <= w_lfsr_next[WIDTH-1:0];
                    r_b      <= w_lfsr_next[2*WIDTH-1:WIDTH];
                    r_settle <= '0;
                    r_state  <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_settle <= r_settle + 4'd1;
                    if (r_settle == SETTLE_LAST) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_test_count <= w_tc_next;
                    if (mif.P != w_golden) begin
                        if (r_err_count != 16'hFFFF) begin
                            r_err_count <= r_err_count + 16'd1;
                        end
                        r_fail_a <= r_a;
                        r_fail_b <= r_b;
                        r_fail_p <= mif.P;
                    end
                    r_state <= (w_tc_next == TEST_LAST) ? S_DONE : S_LOAD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mif.A      = r_a;
    assign mif.B      = r_b;
    assign busy       = (r_state == S_LOAD) || (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign done       = (r_state == S_DONE);
    assign pass       = done && (r_err_count == 16'd0);
    assign test_count = r_test_count;
    assign err_count  = r_err_count;
    assign fail_a     = r_fail_a;
    assign fail_b     = r_fail_b;
    assign fail_p     = r_fail_p;
endmodule

// File: tb/tb_mult_stimulus_checker.sv
// tb/tb_mult_stimulus_checker.sv - directed self-checking bench for mult_stimulus_checker
module tb_mult_stimulus_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic fault = 1'b0;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    mult_if #(.WIDTH(2)) mif1();
    mult_if #(.WIDTH(2)) mif2();

    // multiplier models; fault adds one to every product
    assign mif1.P = {2'b00, mif1.A} * {2'b00, mif1.B} + {3'b000, fault};
    assign mif2.P = {2'b00, mif2.A} * {2'b00, mif2.B};

    logic        busy, done, pass;
    logic [15:0] test_count, err_count;
    logic [1:0]  fail_a, fail_b;
    logic [3:0]  fail_p;

    logic        busy2, done2, pass2;
    logic [15:0] test_count2, err_count2;
    logic [1:0]  fail_a2, fail_b2;
    logic [3:0]  fail_p2;

    mult_stimulus_checker #(.WIDTH(2), .NUM_TESTS(20), .SETTLE_CYCLES(1), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .mif(mif1),
        .busy(busy), .done(done), .pass(pass),
        .test_count(test_count), .err_count(err_count),
        .fail_a(fail_a), .fail_b(fail_b), .fail_p(fail_p)
    );

    mult_stimulus_checker #(.WIDTH(2), .NUM_TESTS(1), .SETTLE_CYCLES(3), .LFSR_SEED(16'hACE1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mif(mif2),
        .busy(busy2), .done(done2), .pass(pass2),
        .test_count(test_count2), .err_count(err_count2),
        .fail_a(fail_a2), .fail_b(fail_b2), .fail_p(fail_p2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    logic [1:0] exp_a [20];
    logic [1:0] exp_b [20];
    logic [1:0] cap_a [20];
    logic [1:0] cap_b [20];

    // Starts a run and returns the edge count (start edge = 1) at which done was first seen.
    task automatic run_test(input bit pulse_busy, output int edges);
        logic [15:0] prev;
        edges = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); edges = 1;
        prev = 16'd0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (test_count != prev && test_count >= 16'd1 && test_count <= 16'd20) begin
                cap_a[test_count - 16'd1] = mif1.A;
                cap_b[test_count - 16'd1] = mif1.B;
            end
            prev = test_count;
            if (done) return;
            if (pulse_busy && (k % 3 == 0)) start = 1'b1;
            @(posedge clk);
            edges++;
        end
        check("run_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_sequence(input string tag);
        for (int i = 0; i < 20; i++) begin
            check({tag, "_a"}, 32'(cap_a[i]), 32'(exp_a[i]));
            check({tag, "_b"}, 32'(cap_b[i]), 32'(exp_b[i]));
        end
    endtask

    initial begin
        int edges;
        logic [15:0] v;
        logic [3:0]  p_exp;

        v = 16'hACE1;
        for (int i = 0; i < 20; i++) begin
            v = lfsr_step(v);
            exp_a[i] = v[1:0];
            exp_b[i] = v[3:2];
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_A", 32'(mif1.A), 32'd0);
        check("rst_B", 32'(mif1.B), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_tc", 32'(test_count), 32'd0);
        check("rst_ec", 32'(err_count), 32'd0);
        check("rst_fail", {20'd0, fail_a, fail_b, fail_p}, 32'd0);
        rst = 1'b0;

        // ideal multiplier, default parameters
        run_test(1'b0, edges);
        check("s1_done_edge", 32'(edges), 32'd61);
        check("s1_tc", 32'(test_count), 32'd20);
        check("s1_ec", 32'(err_count), 32'd0);
        check("s1_pass", 32'(pass), 32'd1);
        check("s1_busy", 32'(busy), 32'd0);
        check("s2_op1_a", 32'(cap_a[0]), 32'd0);
        check("s2_op1_b", 32'(cap_b[0]), 32'd0);
        check("s2_op2_a", 32'(cap_a[1]), 32'd0);
        check("s2_op2_b", 32'(cap_b[1]), 32'd2);
        check("s2_op3_a", 32'(cap_a[2]), 32'd0);
        check("s2_op3_b", 32'(cap_b[2]), 32'd3);
        check_sequence("s2_seq");

        // faulty multiplier, every check mismatches
        fault = 1'b1;
        run_test(1'b0, edges);
        p_exp = {2'b00, exp_a[19]} * {2'b00, exp_b[19]} + 4'd1;
        check("s3_ec", 32'(err_count), 32'd20);
        check("s3_pass", 32'(pass), 32'd0);
        check("s3_done", 32'(done), 32'd1);
        check("s3_fail_a", 32'(fail_a), 32'(exp_a[19]));
        check("s3_fail_b", 32'(fail_b), 32'(exp_b[19]));
        check("s3_fail_p", 32'(fail_p), 32'(p_exp));
        fault = 1'b0;

        // start pulses while busy are ignored; restart from DONE repeats the sequence
        run_test(1'b1, edges);
        check("s4_done_edge", 32'(edges), 32'd61);
        check("s4_tc", 32'(test_count), 32'd20);
        check("s4_ec", 32'(err_count), 32'd0);
        for (int i = 0; i < 20; i++) begin
            cap_a[i] = 2'bxx;
            cap_b[i] = 2'bxx;
        end
        run_test(1'b0, edges);
        check("s4_restart_edge", 32'(edges), 32'd61);
        check_sequence("s4_seq");

        // reset during SETTLE of test 7
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 500 && test_count != 16'd6; k++) @(negedge clk);
        check("s5_tc6", 32'(test_count), 32'd6);
        @(negedge clk);
        check("s5_busy_settle", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s5_A", 32'(mif1.A), 32'd0);
        check("s5_B", 32'(mif1.B), 32'd0);
        check("s5_tc", 32'(test_count), 32'd0);
        check("s5_ec", 32'(err_count), 32'd0);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_done", 32'(done), 32'd0);
        run_test(1'b0, edges);
        check("s5_rerun_tc", 32'(test_count), 32'd20);
        check("s5_rerun_pass", 32'(pass), 32'd1);

        // SETTLE_CYCLES=3, NUM_TESTS=1 instance
        begin
            int e2;
            int held;
            bit seen;
            held = 0;
            seen = 1'b0;
            @(negedge clk); start2 = 1'b1;
            @(posedge clk); e2 = 1;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                start2 = 1'b0;
                if (done2) begin
                    seen = 1'b1;
                    break;
                end
                if (busy2 && mif2.A == 2'd0 && mif2.B == 2'd0) held++;
                @(posedge clk);
                e2++;
            end
            check("s6_seen_done", 32'(seen), 32'd1);
            check("s6_done_edge", 32'(e2), 32'd6);
            check("s6_tc", 32'(test_count2), 32'd1);
            check("s6_pass", 32'(pass2), 32'd1);
            check("s6_busy_cycles", 32'(held), 32'd5);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
